instr_fetch_unit: RTL and testbench

Instruction fetch front end of the single-issue CPU. Owns the program counter and issues in-order, word-addressed read requests to instruction RAM. Buffers returned words in a small prefetch FIFO and hands them, tagged with their PC, to the decoder over a valid/ready handshake. Branch/jump resolution redirects the stream; stale in-flight words are discarded.

---
 rtl/instr_fetch_unit_pkg.sv | 11 +
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_inst_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: word/address widths, reset PC and the matching typedefs.
package instr_fetch_unit_pkg;

    localparam int          WORD_W   = 32;
    localparam int          ADDR_W   = 12;
    localparam int unsigned RESET_PC = 0;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction RAM request/response, redirect input and decoder handshake.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = instr_fetch_unit_pkg::ADDR_W
) ();

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    word_t             mem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              inst_valid;
    logic              inst_ready;
    word_t             inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_addr,
               inst_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_addr,
               inst_ready
    );

endinterface

// File: rtl/instr_fetch_unit_inst_fifo.sv
// Synchronous FIFO with flush; push on a full FIFO is accepted only alongside a pop,
// and an empty FIFO never forwards the pushed word in the same cycle.
module instr_fetch_unit_inst_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [W-1:0]            data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [W-1:0]            data_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the output is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order RAM reads, buffers returned
// words with their PC and discards words that belong to a stream killed by a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = instr_fetch_unit_pkg::ADDR_W,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = instr_fetch_unit_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;
    localparam int TW = WORD_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     live_cnt;
    logic [CW-1:0]     inst_cnt;
    logic [SW-1:0]     busy;
    logic              req_fire, rsp_drop, rsp_keep, inst_fire;
    logic [ADDR_W-1:0] rsp_pc;
    logic [TW-1:0]     inst_entry;

    // Buffered, kept-in-flight and doomed-in-flight words all hold a credit, so the
    // instruction FIFO can never overflow.
    assign busy              = SW'(inst_cnt) + SW'(live_cnt) + SW'(drop_cnt_q);
    assign bus.mem_req_valid = !rst && (busy < SW'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc_q;

    assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_drop  = bus.mem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_keep  = bus.mem_rsp_valid && (drop_cnt_q == '0);
    assign inst_fire = bus.inst_valid && bus.inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            // Everything issued up to and including this cycle is doomed; a response
            // arriving now retires one of those requests.
            fetch_pc_d = bus.redirect_addr;
            drop_cnt_d = CW'(SW'(drop_cnt_q) + SW'(live_cnt) + SW'(req_fire)
                             - SW'(bus.mem_rsp_valid));
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PC tags of kept in-flight requests; its occupancy is the live count.
    instr_fetch_unit_inst_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (rsp_keep),
        .flush_i (bus.redirect_valid),
        .data_o  (rsp_pc),
        .count_o (live_cnt)
    );

    instr_fetch_unit_inst_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_keep && !bus.redirect_valid),
        .data_i  ({bus.mem_rsp_data, rsp_pc}),
        .pop_i   (inst_fire),
        .flush_i (bus.redirect_valid),
        .data_o  (inst_entry),
        .count_o (inst_cnt)
    );

    assign bus.inst_valid = (inst_cnt != '0);
    assign bus.inst_data  = inst_entry[TW-1 -: WORD_W];
    assign bus.inst_pc    = inst_entry[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: in-order RAM model with variable latency and a
// stream-level reference model of the fetched PC sequence.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int             AW     = 12;
    localparam int             DEPTH  = 4;
    localparam logic [AW-1:0]  RST_PC = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    word_t         ram [4096];
    pend_t         pend_q [$];
    int            last_due    = 0;
    int            fixed_lat   = 1;
    bit            rand_lat    = 1'b0;
    int            acc_cnt     = 0;
    int            hs_cnt      = 0;
    logic [AW-1:0] redir_q [$];
    logic [AW-1:0] exp_pc, req_exp, prev_addr;
    bit            prev_stall  = 1'b0;
    bit            saw_fff     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model: accept requests, answer strictly in order after 1..3 cycles.
    always @(negedge clk) begin
        pend_t p;
        int    lat;
        if (rst) begin
            pend_q.delete();
            last_due = 0;
        end else if (bus.mem_req_valid && bus.mem_req_ready) begin
            lat    = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
            p.addr = bus.mem_req_addr;
            p.due  = cyc + lat;
            if (p.due <= last_due) p.due = last_due + 1;
            last_due = p.due;
            pend_q.push_back(p);
            acc_cnt++;
            check("inflight_le_depth", 64'(pend_q.size() <= DEPTH), 64'd1);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = ram[pend_q[0].addr];
            void'(pend_q.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end
    end

    // Monitor: the fetched stream is sequential from the last reset or redirect target.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc     = RST_PC;
            req_exp    = RST_PC;
            prev_stall = 1'b0;
        end else begin
            if (bus.mem_req_valid) begin
                check("req_addr", 64'(bus.mem_req_addr), 64'(req_exp));
                if (prev_stall) check("req_addr_stable", 64'(bus.mem_req_addr), 64'(prev_addr));
            end
            if (bus.inst_valid && bus.inst_ready) begin
                check("inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
                check("inst_data", 64'(bus.inst_data), 64'(ram[exp_pc]));
                if (exp_pc == '1) saw_fff = 1'b1;
                exp_pc = exp_pc + 1'b1;
                hs_cnt++;
            end
            if (bus.redirect_valid) begin
                if (redir_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL redirect_queue: no target queued (cycle %0d)", cyc);
                end else begin
                    exp_pc  = redir_q.pop_front();
                    req_exp = exp_pc;
                end
                prev_stall = 1'b0;
            end else begin
                if (bus.mem_req_valid && bus.mem_req_ready) req_exp = req_exp + 1'b1;
                prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
                prev_addr  = bus.mem_req_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [AW-1:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        redir_q.push_back(a);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_req_addr", 64'(bus.mem_req_addr), 64'(RST_PC));
        check("rst_inst_data", 64'(bus.inst_data), 64'd0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        tick();
        rst     = 1'b0;
        acc_cnt = 0;
    endtask

    initial begin
        int  h0;
        bit  found;
        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        bus.mem_req_ready  = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.inst_ready     = 1'b1;

        // Reset release, latency 1: first instruction in the third cycle, one per cycle.
        fixed_lat = 1;
        do_reset();
        @(negedge clk);
        check("t1_c1_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("t1_c1_inst_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t1_c2_inst_valid", 64'(bus.inst_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("t1_inst_valid", 64'(bus.inst_valid), 64'd1);
            check("t1_inst_pc", 64'(bus.inst_pc), 64'(k));
        end
        repeat (20) tick();

        // Decoder stalled: exactly DEPTH requests, head held at pc 0; then drain.
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        @(negedge clk);
        check("t2_req_count", 64'(acc_cnt), 64'(DEPTH));
        check("t2_inst_valid", 64'(bus.inst_valid), 64'd1);
        check("t2_inst_pc", 64'(bus.inst_pc), 64'd0);
        tick();
        bus.inst_ready = 1'b1;
        h0 = hs_cnt;
        repeat (30) tick();
        check("t2_progress", 64'((hs_cnt - h0) >= 25), 64'd1);

        // Redirect with requests in flight at latency 3.
        fixed_lat = 3;
        repeat (20) tick();
        do_redirect(12'h100);
        h0 = hs_cnt;
        repeat (30) tick();
        check("t3_progress", 64'((hs_cnt - h0) >= 15), 64'd1);

        // Redirect in the same cycle as a decoder handshake and a RAM response.
        fixed_lat = 1;
        repeat (10) tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (bus.inst_valid && bus.inst_ready && bus.mem_rsp_valid) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_addr  = 12'h2A0;
                redir_q.push_back(12'h2A0);
                found = 1'b1;
                tick();
                bus.redirect_valid = 1'b0;
            end
        end
        check("t4_collision_found", 64'(found), 64'd1);
        repeat (20) tick();

        // Address wrap at the top of the RAM.
        saw_fff = 1'b0;
        do_redirect(12'hFFE);
        repeat (20) tick();
        check("t5_wrap_seen", 64'(saw_fff), 64'd1);

        // Random backpressure, latency and redirects.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) do_redirect(AW'($urandom));
        end
        bus.mem_req_ready = 1'b1;
        bus.inst_ready    = 1'b1;
        h0 = hs_cnt;
        repeat (40) tick();
        check("t6_progress", 64'((hs_cnt - h0) >= 20), 64'd1);
        check("t6_redirects_consumed", 64'(redir_q.size()), 64'd0);

        // Reset in the middle of traffic, then restart from the reset PC.
        do_reset();
        h0 = hs_cnt;
        repeat (20) tick();
        check("t7_progress", 64'((hs_cnt - h0) >= 10), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
